// File: rtl/uop_dispatch_queue.sv
// uop_dispatch_queue: in-order uop buffer between decode and execute.
// Each head uop is offered to scalar execute or the vector unit. Serializing
// uops (ifence, wfi, halt) wait for drained pipelines. The queue freezes once
// a halt has been dispatched. A flush empties the queue.
// Optional build macro UOP_DISPATCH_BYPASS_EN: an empty queue forwards a
// non-serializing enqueue straight to the consumers in the same cycle.

package uop_dispatch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_t;

    typedef struct packed {
        logic       ifence;
        logic       wfi;
        logic       halt;
        logic [4:0] op;
    } ctrl_t;

    typedef struct packed {
        logic [5:0] vop;
        logic [2:0] vsew;
    } vctrl_t;

    typedef struct packed {
        fetch_t fetch;
        ctrl_t  ctrl;
        vctrl_t vctrl;
    } uop_t;
endpackage

module uop_dispatch_queue
    import uop_dispatch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             enq_valid,
    input  logic             enq_is_vec,
    input  uop_t             enq_uop,
    output logic             enq_ready,
    input  logic             pipe_empty,
    input  logic             scalar_ready,
    input  logic             vector_ready,
    output logic             scalar_valid,
    output logic             vector_valid,
    output uop_t             deq_uop,
    output logic [CNT_W-1:0] count,
    output logic             halted
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ISSUE,
        SERIAL_WAIT,
        HALT
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    uop_t             mem     [DEPTH];
    logic             vec_mem [DEPTH];

    uop_t head_uop;
    logic head_vec;
    logic empty;
    logic full;
    logic head_sv;
    logic head_vv;
    logic byp;
    logic byp_taken;
    logic push;
    logic pop;

    // Serializing uops must see drained execution pipelines before issue.
    function automatic logic is_serial(input uop_t u);
        return u.ctrl.ifence | u.ctrl.wfi | u.ctrl.halt;
    endfunction

    assign head_uop = mem[head_ptr];
    assign head_vec = vec_mem[head_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

    assign enq_ready = !full && (state != HALT);
    assign halted    = (state == HALT);

`ifdef UOP_DISPATCH_BYPASS_EN
    assign byp       = empty && (state == ISSUE) && enq_valid && !is_serial(enq_uop);
    assign byp_taken = byp && (enq_is_vec ? vector_ready : scalar_ready);
`else
    assign byp       = 1'b0;
    assign byp_taken = 1'b0;
`endif

    // Head offer is a function of registered state only (plus pipe_empty).
    always_comb begin
        head_sv = 1'b0;
        head_vv = 1'b0;
        case (state)
            ISSUE: begin
                if (!empty && !is_serial(head_uop)) begin
                    head_sv = !head_vec;
                    head_vv = head_vec;
                end
            end
            SERIAL_WAIT: begin
                // Serializing ops always retire through the scalar path.
                head_sv = !empty && pipe_empty;
            end
            default: begin
                head_sv = 1'b0;
                head_vv = 1'b0;
            end
        endcase
    end

    // Output mux: bypassed enqueue wins only while the queue is empty.
    always_comb begin
        if (byp) begin
            scalar_valid = !enq_is_vec;
            vector_valid = enq_is_vec;
            deq_uop      = enq_uop;
        end else begin
            scalar_valid = head_sv;
            vector_valid = head_vv;
            deq_uop      = head_uop;
        end
    end

    assign pop  = !byp && ((head_sv && scalar_ready) || (head_vv && vector_ready));
    assign push = enq_valid && enq_ready && !byp_taken;

    // Control state: pointers, occupancy and dispatch FSM.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count    <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            state    <= ISSUE;
        end else if (flush) begin
            count    <= '0;
            head_ptr <= tail_ptr;
            state    <= (state == HALT) ? HALT : ISSUE;
        end else begin
            if (push) begin
                tail_ptr <= tail_ptr + PTR_W'(1);
            end
            if (pop) begin
                head_ptr <= head_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            case (state)
                ISSUE: begin
                    if (!empty && is_serial(head_uop)) begin
                        state <= SERIAL_WAIT;
                    end
                end
                SERIAL_WAIT: begin
                    if (pop) begin
                        state <= head_uop.ctrl.halt ? HALT : ISSUE;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

    // Entry storage; data is not reset, only written on an accepted push.
    always_ff @(posedge CLK) begin
        if (push && !flush) begin
            mem[tail_ptr]     <= enq_uop;
            vec_mem[tail_ptr] <= enq_is_vec;
        end
    end

endmodule

// File: tb/tb_uop_dispatch_queue.sv
// Testbench for uop_dispatch_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.

module tb_uop_dispatch_queue;
    import uop_dispatch_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             CLK;
    logic             RST;
    logic             flush;
    logic             enq_valid;
    logic             enq_is_vec;
    uop_t             enq_uop;
    logic             enq_ready;
    logic             pipe_empty;
    logic             scalar_ready;
    logic             vector_ready;
    logic             scalar_valid;
    logic             vector_valid;
    uop_t             deq_uop;
    logic [CNT_W-1:0] count;
    logic             halted;

    uop_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .enq_valid(enq_valid), .enq_is_vec(enq_is_vec), .enq_uop(enq_uop),
        .enq_ready(enq_ready), .pipe_empty(pipe_empty),
        .scalar_ready(scalar_ready), .vector_ready(vector_ready),
        .scalar_valid(scalar_valid), .vector_valid(vector_valid),
        .deq_uop(deq_uop), .count(count), .halted(halted)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: queue contents plus dispatch mode (0 issue, 1 wait, 2 halted).
    uop_t mq[$];
    bit   mv[$];
    int   mode;

    logic             exp_er, exp_sv, exp_vv, exp_byp, exp_halt;
    logic [CNT_W-1:0] exp_cnt;
    uop_t             exp_uop;

    function automatic bit ser(input uop_t u);
        return u.ctrl.ifence || u.ctrl.wfi || u.ctrl.halt;
    endfunction

    // kind: 0 plain, 1 ifence, 2 wfi, 3 halt
    function automatic uop_t mk(input logic [31:0] pc, input int kind);
        uop_t u;
        u = '0;
        u.fetch.pc    = pc;
        u.fetch.instr = $urandom;
        u.ctrl.op     = 5'($urandom);
        u.vctrl.vop   = 6'($urandom);
        u.vctrl.vsew  = 3'($urandom);
        u.ctrl.ifence = (kind == 1);
        u.ctrl.wfi    = (kind == 2);
        u.ctrl.halt   = (kind == 3);
        return u;
    endfunction

    // Apply inputs for this cycle and derive expected outputs from the model.
    task automatic drive(input bit fl, input bit ev, input bit iv, input uop_t u,
                         input bit pe, input bit sr, input bit vr);
        flush = fl; enq_valid = ev; enq_is_vec = iv; enq_uop = u;
        pipe_empty = pe; scalar_ready = sr; vector_ready = vr;
        #1;
        exp_er   = (mq.size() < DEPTH) && (mode != 2);
        exp_cnt  = CNT_W'(mq.size());
        exp_halt = (mode == 2);
        exp_sv = 0; exp_vv = 0; exp_byp = 0; exp_uop = '0;
        if (mode == 0 && mq.size() > 0 && !ser(mq[0])) begin
            exp_sv = !mv[0]; exp_vv = mv[0]; exp_uop = mq[0];
        end else if (mode == 1 && mq.size() > 0 && pe) begin
            exp_sv = 1; exp_uop = mq[0];
        end
`ifdef UOP_DISPATCH_BYPASS_EN
        if (mode == 0 && mq.size() == 0 && ev && !ser(u)) begin
            exp_byp = 1; exp_sv = !iv; exp_vv = iv; exp_uop = u;
        end
`endif
    endtask

    // Advance the model by the current inputs, then clock the DUT.
    task automatic tick();
        bit   acc;
        uop_t h;
        if (flush) begin
            mq.delete(); mv.delete();
            if (mode != 2) mode = 0;
        end else begin
            acc = (exp_sv && scalar_ready) || (exp_vv && vector_ready);
            if (exp_byp) begin
                if (!acc) begin mq.push_back(enq_uop); mv.push_back(enq_is_vec); end
            end else begin
                if (mode == 0 && mq.size() > 0 && ser(mq[0])) begin
                    mode = 1;
                end else if (acc) begin
                    h = mq.pop_front();
                    void'(mv.pop_front());
                    if (mode == 1) mode = h.ctrl.halt ? 2 : 0;
                end
                if (enq_valid && exp_er) begin
                    mq.push_back(enq_uop); mv.push_back(enq_is_vec);
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        flush = 0; enq_valid = 0; enq_is_vec = 0; enq_uop = '0;
        pipe_empty = 1; scalar_ready = 0; vector_ready = 0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        mq.delete(); mv.delete(); mode = 0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(0, 0, 0, '0, 1, 0, 0);
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_cmp++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL reset_enq_ready got=%b exp=1", enq_ready); end
        n_cmp++; if (scalar_valid !== 1'b0 || vector_valid !== 1'b0) begin n_err++; $display("FAIL reset_valids got=%b%b exp=00", scalar_valid, vector_valid); end
        n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, mk(32'h100 + 32'(4 * i), 0), 1, 0, 0);
            n_cmp++; if (enq_ready !== exp_er) begin n_err++; $display("FAIL fill_enq_ready i=%0d got=%b exp=%b", i, enq_ready, exp_er); end
            if (i == 4) begin
                n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count_full got=%0d exp=4", count); end
                n_cmp++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got=%b exp=0", enq_ready); end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, '0, 1, 1, 0);
            n_cmp++; if (scalar_valid !== 1'b1) begin n_err++; $display("FAIL fill_pop_valid i=%0d got=%b exp=1", i, scalar_valid); end
            n_cmp++; if (deq_uop.fetch.pc !== 32'h100 + 32'(4 * i)) begin n_err++; $display("FAIL fill_pop_pc i=%0d got=%h exp=%h", i, deq_uop.fetch.pc, 32'h100 + 32'(4 * i)); end
            n_cmp++; if (count !== CNT_W'(4 - i)) begin n_err++; $display("FAIL fill_pop_count i=%0d got=%0d exp=%0d", i, count, 4 - i); end
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (count !== '0 || scalar_valid !== 1'b0) begin n_err++; $display("FAIL fill_drained count=%0d sv=%b exp=0/0", count, scalar_valid); end
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        drive(0, 1, 0, mk(32'h200, 0), 1, 0, 0); tick();
        drive(0, 1, 1, mk(32'h204, 0), 1, 0, 0); tick();
        drive(0, 1, 0, mk(32'h208, 0), 1, 0, 0); tick();
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h200) begin n_err++; $display("FAIL alt_first sv=%b pc=%h exp=1/200", scalar_valid, deq_uop.fetch.pc); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, 1, 1, 0);
            n_cmp++; if (vector_valid !== 1'b1 || scalar_valid !== 1'b0) begin n_err++; $display("FAIL alt_stall_valids i=%0d got=%b%b exp=01", i, scalar_valid, vector_valid); end
            n_cmp++; if (deq_uop.fetch.pc !== 32'h204) begin n_err++; $display("FAIL alt_stall_pc i=%0d got=%h exp=204", i, deq_uop.fetch.pc); end
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, 1); tick();
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h208) begin n_err++; $display("FAIL alt_last sv=%b pc=%h exp=1/208", scalar_valid, deq_uop.fetch.pc); end
        tick();
    endtask

    task automatic test_serial();
        do_reset();
        drive(0, 1, 0, mk(32'h300, 1), 0, 1, 0); tick();
        drive(0, 1, 0, mk(32'h304, 0), 0, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b0 || vector_valid !== 1'b0) begin n_err++; $display("FAIL ser_enter got=%b%b exp=00", scalar_valid, vector_valid); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, '0, 0, 1, 1);
            n_cmp++; if (scalar_valid !== 1'b0 || vector_valid !== 1'b0) begin n_err++; $display("FAIL ser_wait i=%0d got=%b%b exp=00", i, scalar_valid, vector_valid); end
            tick();
        end
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h300) begin n_err++; $display("FAIL ser_issue sv=%b pc=%h exp=1/300", scalar_valid, deq_uop.fetch.pc); end
        tick();
        drive(0, 0, 0, '0, 0, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h304) begin n_err++; $display("FAIL ser_next sv=%b pc=%h exp=1/304", scalar_valid, deq_uop.fetch.pc); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        drive(0, 1, 0, mk(32'h400, 3), 1, 1, 0); tick();
        drive(0, 1, 0, mk(32'h404, 0), 1, 1, 0); tick();
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h400) begin n_err++; $display("FAIL halt_issue sv=%b pc=%h exp=1/400", scalar_valid, deq_uop.fetch.pc); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, mk(32'h408, 0), 1, 1, 1);
            n_cmp++; if (halted !== 1'b1 || enq_ready !== 1'b0) begin n_err++; $display("FAIL halt_frozen i=%0d halted=%b er=%b exp=1/0", i, halted, enq_ready); end
            n_cmp++; if (scalar_valid !== 1'b0 || vector_valid !== 1'b0 || count !== 3'd1) begin n_err++; $display("FAIL halt_quiet i=%0d v=%b%b cnt=%0d exp=00/1", i, scalar_valid, vector_valid, count); end
            tick();
        end
        drive(1, 0, 0, '0, 1, 1, 1); tick();
        drive(0, 0, 0, '0, 1, 1, 1);
        n_cmp++; if (halted !== 1'b1 || count !== '0 || enq_ready !== 1'b0) begin n_err++; $display("FAIL halt_flush halted=%b cnt=%0d er=%b exp=1/0/0", halted, count, enq_ready); end
        tick();
        do_reset();
        drive(0, 0, 0, '0, 1, 0, 0);
        n_cmp++; if (halted !== 1'b0 || enq_ready !== 1'b1) begin n_err++; $display("FAIL halt_reset halted=%b er=%b exp=0/1", halted, enq_ready); end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, mk(32'h500 + 32'(4 * i), 0), 1, 0, 0); tick();
        end
        drive(1, 1, 0, mk(32'h50C, 0), 1, 1, 1);
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count got=%0d exp=3", count); end
        tick();
        drive(0, 1, 0, mk(32'h510, 0), 1, 1, 0);
        n_cmp++; if (count !== '0) begin n_err++; $display("FAIL flush_count got=%0d exp=0", count); end
`ifdef UOP_DISPATCH_BYPASS_EN
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h510) begin n_err++; $display("FAIL flush_bypass sv=%b pc=%h exp=1/510", scalar_valid, deq_uop.fetch.pc); end
        tick();
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (count !== '0 || scalar_valid !== 1'b0) begin n_err++; $display("FAIL flush_bypass_after cnt=%0d sv=%b exp=0/0", count, scalar_valid); end
        tick();
`else
        n_cmp++; if (scalar_valid !== 1'b0 || vector_valid !== 1'b0) begin n_err++; $display("FAIL flush_valids got=%b%b exp=00", scalar_valid, vector_valid); end
        tick();
        drive(0, 0, 0, '0, 1, 1, 0);
        n_cmp++; if (scalar_valid !== 1'b1 || deq_uop.fetch.pc !== 32'h510) begin n_err++; $display("FAIL flush_new sv=%b pc=%h exp=1/510", scalar_valid, deq_uop.fetch.pc); end
        tick();
`endif
    endtask

    task automatic test_wrap();
        logic [31:0] seen[$];
        do_reset();
        for (int c = 0; c < 18; c++) begin
            if (c < 10) drive(0, 1, 0, mk(32'h600 + 32'(4 * c), 0), 1, 1, 0);
            else        drive(0, 0, 0, '0, 1, 1, 0);
            if (scalar_valid === 1'b1) seen.push_back(deq_uop.fetch.pc);
            n_cmp++; if (count > 3'd4 || count !== exp_cnt) begin n_err++; $display("FAIL wrap_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); end
            tick();
        end
        n_cmp++; if (seen.size() != 10) begin n_err++; $display("FAIL wrap_num got=%0d exp=10", seen.size()); end
        for (int i = 0; i < 10 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] !== 32'h600 + 32'(4 * i)) begin n_err++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, seen[i], 32'h600 + 32'(4 * i)); end
        end
    endtask

    task automatic test_random();
        int   k;
        uop_t u;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            k = $urandom_range(0, 19);
            u = mk($urandom, (k == 0) ? 1 : (k == 1) ? 2 : 0);
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 1),
                  u, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
            n_cmp++; if (count !== exp_cnt) begin n_err++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, count, exp_cnt); end
            n_cmp++; if (enq_ready !== exp_er) begin n_err++; $display("FAIL rnd_enq_ready c=%0d got=%b exp=%b", c, enq_ready, exp_er); end
            n_cmp++; if (scalar_valid !== exp_sv) begin n_err++; $display("FAIL rnd_scalar_valid c=%0d got=%b exp=%b", c, scalar_valid, exp_sv); end
            n_cmp++; if (vector_valid !== exp_vv) begin n_err++; $display("FAIL rnd_vector_valid c=%0d got=%b exp=%b", c, vector_valid, exp_vv); end
            n_cmp++; if (halted !== exp_halt) begin n_err++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, halted, exp_halt); end
            if (exp_sv || exp_vv) begin
                n_cmp++; if (deq_uop !== exp_uop) begin n_err++; $display("FAIL rnd_deq_uop c=%0d got=%h exp=%h", c, deq_uop, exp_uop); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_alternate();
        test_serial();
        test_halt();
        test_flush();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
